// File: rtl/arith_pipe_pkg.sv
// Shared types and helpers for the arith_pipe block.
// Mode encoding and elaboration-time parameter range check.
package arith_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_ADD12 = 2'd0,
    MODE_ADD23 = 2'd1,
    MODE_SUB12 = 2'd2,
    MODE_SAT3  = 2'd3
  } mode_t;

  function automatic bit params_ok(
    int w,
    int d,
    int c,
    int t
  );
    return (w >= 8) && (d >= 1) && (d <= 4) &&
           (c >= 1) && (c <= w) &&
           (t >= 1) && (t <= 255);
  endfunction

endpackage

// File: rtl/arith_pipe_if.sv
// Operand/result handshake bundle for arith_pipe.
// master drives operands and sink ready; slave is the block.
interface arith_pipe_if
  import arith_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CUT_W = 10
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [WIDTH-1:0]   op3;
  mode_t              mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     res;
  logic [CUT_W-1:0]   cut;
  logic [2*WIDTH-1:0] comb;
  logic               intr;
  logic               intr_clr;
  logic [7:0]         evt_cnt;

  modport master (
    output in_valid, op1, op2, op3, mode,
    output out_ready, intr_clr,
    input  in_ready, out_valid, res, cut, comb,
    input  intr, evt_cnt
  );

  modport slave (
    input  in_valid, op1, op2, op3, mode,
    input  out_ready, intr_clr,
    output in_ready, out_valid, res, cut, comb,
    output intr, evt_cnt
  );
endinterface

// File: rtl/arith_pipe_stage.sv
// One elastic register slot: holds a payload until downstream takes it.
// Accepts a new word when empty or when draining in the same cycle.
module pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [PW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [PW-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_valid && up_ready) begin
      dn_valid <= 1'b1;
      dn_data  <= up_data;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/arith_pipe.sv
// Pipelined operand/result block: compute in front, DEPTH elastic
// stages behind, flag-bit event counter with sticky interrupt.
module arith_pipe
  import arith_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int CUT_W       = 10,
  parameter int INTR_THRESH = 16
) (
  input logic         clk,
  input logic         rst,
  arith_pipe_if.slave bus
);

  localparam int PW = WIDTH + 1 + CUT_W + 2 * WIDTH;
  localparam logic [7:0] THR = 8'(INTR_THRESH);

  if (!params_ok(WIDTH, DEPTH, CUT_W, INTR_THRESH)) begin : g_bad
    $error("arith_pipe: parameter out of range");
  end

  logic [WIDTH+1:0] sum3;
  logic [WIDTH:0]   res_c;

  always_comb begin
    res_c = '0;
    sum3  = {2'b0, bus.op1} + {2'b0, bus.op2} + {2'b0, bus.op3};
    unique case (bus.mode)
      MODE_ADD12: res_c = {1'b0, bus.op1} + {1'b0, bus.op2};
      MODE_ADD23: res_c = {1'b0, bus.op2} + {1'b0, bus.op3};
      // top bit of the WIDTH+1 difference is the unsigned borrow
      MODE_SUB12: res_c = {1'b0, bus.op1} - {1'b0, bus.op2};
      MODE_SAT3:  res_c = sum3[WIDTH+1] ? '1 : sum3[WIDTH:0];
      default:    res_c = '0;
    endcase
  end

  logic [DEPTH:0]         v;
  logic [DEPTH:0]         rdy;
  logic [DEPTH:0][PW-1:0] d;

  assign v[0]   = bus.in_valid;
  assign d[0]   = {res_c, bus.op1[CUT_W-1:0], bus.op1, bus.op2};
  assign rdy[DEPTH] = bus.out_ready;
  assign bus.in_ready = rdy[0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(.PW(PW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (v[i]),
      .up_ready (rdy[i]),
      .up_data  (d[i]),
      .dn_valid (v[i+1]),
      .dn_ready (rdy[i+1]),
      .dn_data  (d[i+1])
    );
  end

  assign bus.out_valid = v[DEPTH];
  assign {bus.res, bus.cut, bus.comb} = d[DEPTH];

  logic       evt;
  logic [7:0] cnt_q, cnt_d;
  logic       intr_q, intr_d;

  assign evt = bus.out_valid && bus.out_ready && bus.res[WIDTH];

  always_comb begin
    cnt_d  = cnt_q;
    intr_d = intr_q;
    if (bus.intr_clr) begin
      cnt_d  = evt ? 8'd1 : 8'd0;
      intr_d = 1'b0;
    end else begin
      if (evt && cnt_q != THR) cnt_d = cnt_q + 8'd1;
      intr_d = intr_q || (cnt_d == THR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      intr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      intr_q <= intr_d;
    end
  end

  assign bus.evt_cnt = cnt_q;
  assign bus.intr    = intr_q;

endmodule

// File: tb/tb_arith_pipe.sv
// Directed-vector bench for arith_pipe (WIDTH=32, DEPTH=2).
// Expected values are hand-computed constants.
module tb_arith_pipe;
  import arith_pipe_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  arith_pipe_if #(.WIDTH(32), .CUT_W(10)) bus ();

  arith_pipe #(
    .WIDTH(32), .DEPTH(2), .CUT_W(10), .INTR_THRESH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(mode_t m, logic [31:0] a, logic [31:0] b,
                      logic [31:0] c);
    int n;
    n = 0;
    bus.mode     = m;
    bus.op1      = a;
    bus.op2      = b;
    bus.op3      = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("send_timeout", 64'(n), 64'd0);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic get_out(string tag, logic [32:0] exp, bit clr);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_res"}, 64'(bus.res), 64'(exp));
    bus.intr_clr = clr;
    step();
    bus.intr_clr = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op1       = 32'h1234_5678;
    bus.op2       = 32'h0000_0001;
    bus.op3       = 32'h0;
    bus.mode      = MODE_ADD12;
    bus.out_ready = 1'b1;
    bus.intr_clr  = 1'b0;

    // reset held 3 cycles with in_valid=1
    repeat (3) step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_intr", 64'(bus.intr), 64'd0);
    chk("rst_evt_cnt", 64'(bus.evt_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_res", 64'(bus.res), 64'd0);
    chk("rst_comb", bus.comb, 64'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("rst_nothing_out", 64'(bus.out_valid), 64'd0);

    // mode 0 carry, latency exactly 2
    send(MODE_ADD12, 32'hFFFF_FFFF, 32'h1, 32'h0);
    chk("lat_c1", 64'(bus.out_valid), 64'd0);
    step();
    chk("lat_c2", 64'(bus.out_valid), 64'd1);
    chk("m0_res", 64'(bus.res), 64'h1_0000_0000);
    chk("m0_cut", 64'(bus.cut), 64'h3FF);
    chk("m0_comb", bus.comb, 64'hFFFF_FFFF_0000_0001);
    step();
    chk("m0_evt_cnt", 64'(bus.evt_cnt), 64'd1);
    chk("m0_drained", 64'(bus.out_valid), 64'd0);

    // mode 2 with and without borrow
    send(MODE_SUB12, 32'd5, 32'd7, 32'd0);
    get_out("m2_borrow", 33'h1_FFFF_FFFE, 1'b0);
    send(MODE_SUB12, 32'd7, 32'd5, 32'd0);
    get_out("m2_noborrow", 33'h0_0000_0002, 1'b0);
    chk("m2_evt_cnt", 64'(bus.evt_cnt), 64'd2);

    // mode 1 carry, mode 3 unsaturated
    send(MODE_ADD23, 32'h1, 32'h8000_0000, 32'h8000_0000);
    get_out("m1", 33'h1_0000_0000, 1'b0);
    send(MODE_SAT3, 32'd1, 32'd2, 32'd3);
    get_out("m3_small", 33'd6, 1'b0);
    chk("m13_evt_cnt", 64'(bus.evt_cnt), 64'd3);

    // clear without an event
    bus.intr_clr = 1'b1;
    step();
    bus.intr_clr = 1'b0;
    chk("clr_evt_cnt", 64'(bus.evt_cnt), 64'd0);

    // backpressure: capacity 2, order kept
    bus.out_ready = 1'b0;
    send(MODE_ADD12, 32'd1, 32'd0, 32'd0);
    send(MODE_ADD12, 32'd2, 32'd0, 32'd0);
    bus.mode     = MODE_ADD12;
    bus.op1      = 32'd3;
    bus.op2      = 32'd0;
    bus.in_valid = 1'b1;
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    step();
    chk("bp_stall_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_stall_res", 64'(bus.res), 64'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_o2_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_o2_res", 64'(bus.res), 64'd2);
    step();
    chk("bp_o3_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_o3_res", 64'(bus.res), 64'd3);
    step();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);
    chk("bp_evt_cnt", 64'(bus.evt_cnt), 64'd0);

    // saturation events up to the threshold
    for (int i = 0; i < 16; i++) begin
      send(MODE_SAT3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      get_out("sat", 33'h1_FFFF_FFFF, 1'b0);
      chk("sat_cnt", 64'(bus.evt_cnt), 64'(i + 1));
      chk("sat_intr", 64'(bus.intr), 64'(i == 15));
    end
    send(MODE_SAT3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("intr_sticky", 64'(bus.intr), 64'd1);
    chk("cnt_saturated", 64'(bus.evt_cnt), 64'd16);
    get_out("sat17", 33'h1_FFFF_FFFF, 1'b1);
    chk("clr_evt_intr", 64'(bus.intr), 64'd0);
    chk("clr_evt_cnt1", 64'(bus.evt_cnt), 64'd1);

    // reset with a full, stalled pipeline
    bus.out_ready = 1'b0;
    send(MODE_ADD12, 32'hA, 32'd0, 32'd0);
    send(MODE_ADD12, 32'hB, 32'd0, 32'd0);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    send(MODE_ADD12, 32'hC, 32'd0, 32'd0);
    step();
    chk("post_rst_cut", 64'(bus.cut), 64'hC);
    get_out("post_rst", 33'hC, 1'b0);
    chk("post_rst_empty", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
